// File: rtl/prog_seq_ctr.sv
// Program counter / fetch sequencer that runs NPROG programs from a base-address table.
// It supports absolute jumps, relative branches, call/return through a return stack, and sticky stack error flags.
module prog_seq_ctr #(
    parameter int                        A         = 10,
    parameter int                        TW        = 8,
    parameter int                        NPROG     = 3,
    parameter logic [NPROG-1:0][A-1:0]   PROG_BASE = {10'd500, 10'd200, 10'd0},
    parameter int                        BR_MODE   = 0,
    parameter int                        SD        = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_halt,
    input  logic          i_branchAbsEn,
    input  logic          i_branchRelEn,
    input  logic          i_aluFlag,
    input  logic          i_callEn,
    input  logic          i_retEn,
    input  logic [TW-1:0] i_target,
    output logic [A-1:0]  o_progCtr,
    output logic [3:0]    o_progIdx,
    output logic          o_running,
    output logic          o_done,
    output logic          o_stackOvf,
    output logic          o_stackUnf
);

    localparam int             SPW      = $clog2(SD + 1);
    localparam logic [SPW-1:0] SP_FULL  = SPW'(SD);
    localparam logic [3:0]     LAST_IDX = 4'(NPROG);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    logic           r_startQ;
    logic [A-1:0]   r_progCtr;
    logic [3:0]     r_progIdx;
    logic           r_running;
    logic           r_done;
    logic           r_stackOvf;
    logic           r_stackUnf;
    logic [SPW-1:0] r_sp;
    logic [A-1:0]   r_stack [SD];

    logic           w_rise;
    logic           w_fall;
    logic           w_stackFull;
    logic           w_stackEmpty;
    logic           w_lastProg;
    logic [A-1:0]   w_base;
    logic [A-1:0]   w_pcInc;
    logic [A-1:0]   w_tgtZext;
    logic [A-1:0]   w_tgtSext;
    logic [A-1:0]   w_relTarget;
    logic [A-1:0]   w_callTarget;
    logic [A-1:0]   w_stackTop;

    function automatic logic [A-1:0] baseOf(input logic [3:0] idx);
        logic [A-1:0] b;
        b = '0;
        for (int k = 0; k < NPROG; k++) begin
            if (idx == 4'(k + 1)) b = PROG_BASE[k];
        end
        return b;
    endfunction

    // A target field wider than the address is simply truncated to A bits.
    if (TW >= A) begin : g_tgtWide
        assign w_tgtZext = i_target[A-1:0];
        assign w_tgtSext = i_target[A-1:0];
    end else begin : g_tgtNarrow
        assign w_tgtZext = {{(A-TW){1'b0}}, i_target};
        assign w_tgtSext = {{(A-TW){i_target[TW-1]}}, i_target};
    end

    assign w_rise       = i_start & ~r_startQ;
    assign w_fall       = ~i_start & r_startQ;
    assign w_stackFull  = (r_sp == SP_FULL);
    assign w_stackEmpty = (r_sp == '0);
    assign w_lastProg   = (r_progIdx == LAST_IDX);
    assign w_base       = baseOf(r_progIdx);
    assign w_pcInc      = r_progCtr + A'(1);
    assign w_callTarget = w_base + w_tgtZext;
    assign w_relTarget  = (BR_MODE != 0) ? (r_progCtr + w_tgtSext) : w_callTarget;

    always_comb begin
        w_stackTop = '0;
        for (int k = 0; k < SD; k++) begin
            if (r_sp == SPW'(k + 1)) w_stackTop = r_stack[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_startQ   <= 1'b0;
            r_progCtr  <= '0;
            r_progIdx  <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_stackOvf <= 1'b0;
            r_stackUnf <= 1'b0;
            r_sp       <= '0;
            for (int k = 0; k < SD; k++) r_stack[k] <= '0;
        end else begin
            r_startQ <= i_start;
            // A new Start request aborts a running program exactly as if it had come in IDLE.
            if ((r_state == S_IDLE || r_state == S_RUN) && w_rise) begin
                r_running <= 1'b0;
                if (w_lastProg) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end else begin
                    r_progIdx <= r_progIdx + 4'd1;
                    r_sp      <= '0;
                    r_state   <= S_ARMED;
                end
            end else begin
                case (r_state)
                    S_ARMED: begin
                        if (w_fall) begin
                            r_progCtr <= w_base;
                            r_running <= 1'b1;
                            r_state   <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (i_halt) begin
                            r_running <= 1'b0;
                            if (w_lastProg) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else if (i_retEn) begin
                            if (w_stackEmpty) begin
                                r_progCtr  <= w_pcInc;
                                r_stackUnf <= 1'b1;
                            end else begin
                                r_progCtr <= w_stackTop;
                                r_sp      <= r_sp - SPW'(1);
                            end
                        end else if (i_callEn) begin
                            r_progCtr <= w_callTarget;
                            if (w_stackFull) begin
                                r_stackOvf <= 1'b1;
                            end else begin
                                for (int k = 0; k < SD; k++) begin
                                    if (r_sp == SPW'(k)) r_stack[k] <= w_pcInc;
                                end
                                r_sp <= r_sp + SPW'(1);
                            end
                        end else if (i_branchAbsEn) begin
                            r_progCtr <= w_tgtZext;
                        end else if (i_branchRelEn && i_aluFlag) begin
                            r_progCtr <= w_relTarget;
                        end else begin
                            r_progCtr <= w_pcInc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_progCtr  = r_progCtr;
    assign o_progIdx  = r_progIdx;
    assign o_running  = r_running;
    assign o_done     = r_done;
    assign o_stackOvf = r_stackOvf;
    assign o_stackUnf = r_stackUnf;

endmodule
